// File: rtl/simplerisc_prog_loader.sv
// ---------------------------------------------------------------------------
// simplerisc_prog_loader
//
// Writer side of the SimpleRISC instruction memory. A host byte stream is
// framed as:
//   SYNC_BYTE, len[15:8], len[7:0], 4*len data bytes (big-endian words)
//   [, one checksum byte when SIMPLERISC_LOADER_CHECKSUM_EN is defined]
// Each assembled word is written to consecutive imem word addresses.
// The core is held in reset until the whole image has been loaded correctly.
//
// Optional feature macro: SIMPLERISC_LOADER_CHECKSUM_EN
//   defined   : a trailing XOR checksum byte over all data bytes is checked
//   undefined : the frame ends after the last data byte
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-high reset
//   i_in_valid      input byte valid
//   i_in_data       input byte
//   o_in_ready      loader can accept a byte (never back-pressures)
//   o_mem_we        imem write strobe, one cycle per word
//   o_mem_waddr     imem word address
//   o_mem_wdata     instruction word
//   o_cpu_hold      high = core held in reset
//   o_load_done     image loaded successfully (level)
//   o_load_err      frame error (sticky until next sync or reset)
//   o_words_loaded  words written in the current frame
// ---------------------------------------------------------------------------
module simplerisc_prog_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          MEM_WORDS = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_waddr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_load_done,
  output logic              o_load_err,
  output logic [15:0]       o_words_loaded
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
    ST_CHECK  = 3'd4,
`endif
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  state_t              r_state;
  logic                r_inReady;
  logic                r_memWe;
  logic [ADDR_W-1:0]   r_memWaddr;
  logic [31:0]         r_memWdata;
  logic                r_cpuHold;
  logic                r_loadDone;
  logic                r_loadErr;
  logic [15:0]         r_wordsLoaded;
  logic [15:0]         r_len;
  logic [1:0]          r_byteCnt;
  logic [23:0]         r_shift;
`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
  logic [7:0]          r_csum;
`endif

  logic                w_xfer;
  logic                w_isSync;
  logic                w_restart;
  logic [15:0]         w_lenNext;
  logic                w_lenBad;
  logic                w_lastWord;

  assign w_xfer     = i_in_valid && r_inReady;
  assign w_isSync   = (i_in_data == SYNC_BYTE);
  // Sync only restarts from the idle/terminal states; inside a frame it is data.
  assign w_restart  = w_isSync &&
                      ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR));
  assign w_lenNext  = {r_len[15:8], i_in_data};
  assign w_lenBad   = (w_lenNext == 16'd0) || (w_lenNext > 16'(MEM_WORDS));
  assign w_lastWord = ((r_wordsLoaded + 16'd1) == r_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_inReady     <= 1'b0;
      r_memWe       <= 1'b0;
      r_memWaddr    <= '0;
      r_memWdata    <= '0;
      r_cpuHold     <= 1'b1;
      r_loadDone    <= 1'b0;
      r_loadErr     <= 1'b0;
      r_wordsLoaded <= '0;
      r_len         <= '0;
      r_byteCnt     <= '0;
      r_shift       <= '0;
`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
      r_csum        <= '0;
`endif
    end else begin
      r_inReady <= 1'b1;
      r_memWe   <= 1'b0;

      if (w_xfer && w_restart) begin
        r_state       <= ST_LEN_HI;
        r_wordsLoaded <= '0;
        r_byteCnt     <= '0;
        r_cpuHold     <= 1'b1;
        r_loadDone    <= 1'b0;
        r_loadErr     <= 1'b0;
`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
        r_csum        <= '0;
`endif
      end else if (w_xfer) begin
        case (r_state)
          ST_LEN_HI: begin
            r_len[15:8] <= i_in_data;
            r_state     <= ST_LEN_LO;
          end

          ST_LEN_LO: begin
            r_len[7:0] <= i_in_data;
            if (w_lenBad) begin
              r_state    <= ST_ERROR;
              r_loadErr  <= 1'b1;
              r_loadDone <= 1'b0;
              r_cpuHold  <= 1'b1;
            end else begin
              r_state <= ST_DATA;
            end
          end

          ST_DATA: begin
`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ i_in_data;
`endif
            r_byteCnt <= r_byteCnt + 2'd1;
            if (r_byteCnt == 2'd3) begin
              // Address uses the pre-increment count; the count itself moves
              // on in the same edge so the strobe cycle already shows it.
              r_memWe       <= 1'b1;
              r_memWdata    <= {r_shift, i_in_data};
              r_memWaddr    <= r_wordsLoaded[ADDR_W-1:0];
              r_wordsLoaded <= r_wordsLoaded + 16'd1;
              if (w_lastWord) begin
`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
                r_state <= ST_CHECK;
`else
                r_state <= ST_DONE;
`endif
              end
            end else begin
              r_shift <= {r_shift[15:0], i_in_data};
            end
          end

`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
          ST_CHECK: begin
            if (i_in_data == r_csum) begin
              r_state    <= ST_DONE;
              r_loadDone <= 1'b1;
              r_cpuHold  <= 1'b0;
            end else begin
              r_state    <= ST_ERROR;
              r_loadErr  <= 1'b1;
              r_loadDone <= 1'b0;
              r_cpuHold  <= 1'b1;
            end
          end
`endif

          default: begin
          end
        endcase
      end

      // Releasing the core one cycle after entering DONE places load_done
      // right after the final write strobe.
      if ((r_state == ST_DONE) && !(w_xfer && w_restart)) begin
        r_loadDone <= 1'b1;
        r_cpuHold  <= 1'b0;
      end
    end
  end

  assign o_in_ready     = r_inReady;
  assign o_mem_we       = r_memWe;
  assign o_mem_waddr    = r_memWaddr;
  assign o_mem_wdata    = r_memWdata;
  assign o_cpu_hold     = r_cpuHold;
  assign o_load_done    = r_loadDone;
  assign o_load_err     = r_loadErr;
  assign o_words_loaded = r_wordsLoaded;

endmodule
